// File: rtl/face_pipe_ctrl_if.sv
// Register port and input-stream sideband shared between the pipeline host and face_pipe_ctrl.
// The host drives the master side; the sequencer sits on the slave side.
interface face_pipe_ctrl_if;
    logic        i_cfg_wr;
    logic        i_cfg_rd;
    logic [1:0]  i_cfg_addr;
    logic [31:0] i_cfg_wdata;
    logic [31:0] o_cfg_rdata;
    logic        o_cfg_rvalid;
    logic        i_tvalid;
    logic        i_tuser;
    logic        i_tlast;

    modport master (
        output i_cfg_wr, i_cfg_rd, i_cfg_addr, i_cfg_wdata,
        output i_tvalid, i_tuser, i_tlast,
        input  o_cfg_rdata, o_cfg_rvalid
    );

    modport slave (
        input  i_cfg_wr, i_cfg_rd, i_cfg_addr, i_cfg_wdata,
        input  i_tvalid, i_tuser, i_tlast,
        output o_cfg_rdata, o_cfg_rvalid
    );
endinterface

// File: rtl/face_pipe_ctrl.sv
// Frame sequencer and shadowed-configuration register block for the face-recognition pipeline.
// Follows beat/line position from the stream sideband, gates the pipeline per frame, flags geometry errors.
module face_pipe_ctrl #(
    parameter int PARALLEL_NUM = 4,
    parameter int H_ACTIVE     = 1920,
    parameter int V_ACTIVE     = 1080
) (
    input  logic             i_clk,
    input  logic             i_rst,
    face_pipe_ctrl_if.slave  bus,
    output logic             o_enable,
    output logic             o_bypass,
    output logic [23:0]      o_border_rgb,
    output logic             o_frame_done,
    output logic             o_err
);
    localparam int BPL    = H_ACTIVE / PARALLEL_NUM;
    localparam int BEAT_W = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int LINE_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BPL - 1);
    localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(V_ACTIVE - 1);
    localparam logic [23:0]       BORDER_RST = 24'hFF0000;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_BORDER = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_FCNT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic               oneshot_q, oneshot_d;
    logic               bypass_sh_q, bypass_sh_d;
    logic [23:0]        border_sh_q, border_sh_d;
    logic               bypass_act_q, bypass_act_d;
    logic [23:0]        border_act_q, border_act_d;
    logic               enable_q, enable_d;
    logic               frame_done_q, frame_done_d;
    logic               err_line_q, err_line_d;
    logic               err_frame_q, err_frame_d;
    logic               err_q, err_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic wr_ctrl, wr_border, wr_status;
    logic at_line_end, set_line, set_frame, load_cfg, restart;
    logic unused_wdata;

    assign wr_ctrl     = bus.i_cfg_wr && (bus.i_cfg_addr == A_CTRL);
    assign wr_border   = bus.i_cfg_wr && (bus.i_cfg_addr == A_BORDER);
    assign wr_status   = bus.i_cfg_wr && (bus.i_cfg_addr == A_STATUS);
    assign at_line_end = (beat_q == BEAT_LAST);
    assign unused_wdata = ^bus.i_cfg_wdata[31:24];

    always_comb begin
        en_d         = en_q;
        oneshot_d    = oneshot_q;
        bypass_sh_d  = bypass_sh_q;
        border_sh_d  = border_sh_q;
        bypass_act_d = bypass_act_q;
        border_act_d = border_act_q;
        state_d      = state_q;
        beat_d       = beat_q;
        line_d       = line_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        set_line     = 1'b0;
        set_frame    = 1'b0;
        load_cfg     = 1'b0;
        restart      = 1'b0;

        if (wr_ctrl) begin
            en_d        = bus.i_cfg_wdata[0];
            bypass_sh_d = bus.i_cfg_wdata[1];
            oneshot_d   = bus.i_cfg_wdata[2];
        end
        if (wr_border) begin
            border_sh_d = bus.i_cfg_wdata[23:0];
        end

        // Transitions look at EN after this cycle's write so a clear takes effect immediately.
        case (state_q)
            ST_IDLE: begin
                load_cfg = 1'b1;
                if (en_d) state_d = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (!en_d) begin
                    state_d = ST_IDLE;
                end else if (bus.i_tvalid && bus.i_tuser) begin
                    restart = 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (bus.i_tvalid) begin
                    if (bus.i_tuser) begin
                        set_frame = 1'b1;
                        restart   = 1'b1;
                    end else begin
                        if (bus.i_tlast != at_line_end) set_line = 1'b1;
                        if (bus.i_tlast || at_line_end) begin
                            beat_d = '0;
                            if (line_q == LINE_LAST) begin
                                line_d       = '0;
                                frame_done_d = 1'b1;
                                frame_cnt_d  = frame_cnt_q + 16'd1;
                                if (oneshot_d) begin
                                    en_d    = 1'b0;
                                    state_d = ST_IDLE;
                                end else if (!en_d) begin
                                    state_d = ST_IDLE;
                                end else begin
                                    state_d = ST_WAIT_SOF;
                                end
                            end else begin
                                line_d = line_q + LINE_W'(1);
                            end
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The SOF beat itself is beat 0, so counting resumes at beat 1 (or the next line if it also closes a line).
        if (restart) begin
            load_cfg = 1'b1;
            beat_d   = bus.i_tlast ? BEAT_W'(0) : BEAT_W'(1);
            line_d   = bus.i_tlast ? LINE_W'(1) : LINE_W'(0);
        end
        if (load_cfg) begin
            bypass_act_d = bypass_sh_q;
            border_act_d = border_sh_q;
        end

        err_line_d  = (err_line_q  & ~(wr_status & bus.i_cfg_wdata[0])) | set_line;
        err_frame_d = (err_frame_q & ~(wr_status & bus.i_cfg_wdata[1])) | set_frame;
        err_d       = err_line_d | err_frame_d;
        enable_d    = (state_d != ST_IDLE);

        rvalid_d = bus.i_cfg_rd;
        rdata_d  = 32'd0;
        if (bus.i_cfg_rd) begin
            case (bus.i_cfg_addr)
                A_CTRL:   rdata_d = {29'd0, oneshot_q, bypass_sh_q, en_q};
                A_BORDER: rdata_d = {8'd0, border_sh_q};
                A_STATUS: rdata_d = {28'd0, state_q, err_frame_q, err_line_q};
                A_FCNT:   rdata_d = {16'd0, frame_cnt_q};
                default:  rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            en_q         <= 1'b0;
            oneshot_q    <= 1'b0;
            bypass_sh_q  <= 1'b0;
            border_sh_q  <= BORDER_RST;
            bypass_act_q <= 1'b0;
            border_act_q <= BORDER_RST;
            enable_q     <= 1'b0;
            frame_done_q <= 1'b0;
            err_line_q   <= 1'b0;
            err_frame_q  <= 1'b0;
            err_q        <= 1'b0;
            frame_cnt_q  <= 16'd0;
            beat_q       <= '0;
            line_q       <= '0;
            rdata_q      <= 32'd0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            oneshot_q    <= oneshot_d;
            bypass_sh_q  <= bypass_sh_d;
            border_sh_q  <= border_sh_d;
            bypass_act_q <= bypass_act_d;
            border_act_q <= border_act_d;
            enable_q     <= enable_d;
            frame_done_q <= frame_done_d;
            err_line_q   <= err_line_d;
            err_frame_q  <= err_frame_d;
            err_q        <= err_d;
            frame_cnt_q  <= frame_cnt_d;
            beat_q       <= beat_d;
            line_q       <= line_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign o_enable         = enable_q;
    assign o_bypass         = bypass_act_q;
    assign o_border_rgb     = border_act_q;
    assign o_frame_done     = frame_done_q;
    assign o_err            = err_q;
    assign bus.o_cfg_rdata  = rdata_q;
    assign bus.o_cfg_rvalid = rvalid_q;
endmodule

// File: doc/face_pipe_ctrl.md
# face_pipe_ctrl

Frame-level sequencer and configuration controller for the face-recognition video pipeline (skin detect, dilate, erode, skin-select/border). It monitors the 4-pixel-parallel AXI-Stream sideband at the pipeline input, gates the pipeline on frame boundaries, and applies shadowed configuration (bypass, border colour) only at start-of-frame. It also checks line and frame geometry and reports sticky errors and a frame counter through a small register port.

## Interface
Parameters
- PARALLEL_NUM, 4, pixels per beat
- H_ACTIVE, 1920, active pixels per line; beats per line BPL = H_ACTIVE/PARALLEL_NUM (480)
- V_ACTIVE, 1080, active lines per frame

Ports
- i_clk  in  1  pipeline clock; single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_cfg_wr  in  1  register write strobe
- i_cfg_rd  in  1  register read strobe
- i_cfg_addr  in  2  register address
- i_cfg_wdata  in  32  write data
- o_cfg_rdata  out  32  read data, valid with o_cfg_rvalid
- o_cfg_rvalid  out  1  one-cycle read-data strobe
- i_tvalid, i_tuser, i_tlast  in  1 each  input stream sideband (monitor only; no backpressure)
- o_enable  out  1  pipeline run enable
- o_bypass  out  1  active bypass select (pass original pixels)
- o_border_rgb  out  24  active border colour {R,G,B}
- o_frame_done  out  1  one-cycle pulse at the end of each completed frame
- o_err  out  1  OR of sticky error bits

## Operation
- Registers:
  - 0 CTRL (RW): bit0 EN, bit1 BYPASS, bit2 ONESHOT; reset 0.
  - 1 BORDER (RW): [23:0] RGB; reset 24'hFF0000.
  - 2 STATUS: bit0 ERR_LINE, bit1 ERR_FRAME (W1C); [3:2] state (RO).
  - 3 FRAME_CNT (RO): [15:0], wraps 16'hFFFF→0.
- BYPASS and BORDER writes go to shadow registers. Active copies (o_bypass, o_border_rgb) load from the shadows every cycle in IDLE, and in WAIT_SOF on the SOF beat.
- State machine (encoding 0..2):
  - IDLE: o_enable=0. Moves to WAIT_SOF when EN=1.
  - WAIT_SOF: o_enable=1. Beats without tuser are ignored. On i_tvalid&i_tuser: load active config, set beat=1 (or beat=0, line=1 if tlast is also set), go to ACTIVE.
  - ACTIVE: beat counter 0..BPL-1 and line counter 0..V_ACTIVE-1 advance on i_tvalid.
- End of line: i_tlast, or beat==BPL-1 without i_tlast. If the two disagree, set ERR_LINE; either way, reset beat to 0 and increment line.
- End of frame: end of line while line==V_ACTIVE-1. Pulse o_frame_done and increment FRAME_CNT. If ONESHOT, clear EN and go to IDLE; else if EN=0, go to IDLE; else go to WAIT_SOF.
- A tuser beat in ACTIVE that is not the first beat of a frame sets ERR_FRAME. That beat restarts the frame as SOF (config reload, counters restart); FRAME_CNT and o_frame_done are not affected.
- Clearing EN mid-frame is graceful: the current frame completes, then the block enters IDLE. Clearing EN in WAIT_SOF enters IDLE on the next cycle.
- If a W1C clear and an error set occur in the same cycle, the set wins.
- Reads: o_cfg_rdata/o_cfg_rvalid are registered, 1-cycle latency. Unused bits read 0. Writes to read-only fields are ignored.

## Timing
- Reset values: o_enable=0, o_bypass=0, o_border_rgb=24'hFF0000, o_frame_done=0, o_err=0, o_cfg_rvalid=0, o_cfg_rdata=0. State=IDLE, counters=0.
- Asserting i_rst mid-frame returns everything to reset values on the next edge; a frame in progress is abandoned with no error flagged.
- All outputs are registered.
- o_enable rises 1 cycle after the EN write in IDLE.
- Active config changes 1 cycle after the SOF beat is sampled.
- o_frame_done is high the cycle after the final tlast beat.
- Back-to-back frames: a SOF on the beat immediately after the final tlast is accepted with no loss.
- Cycles with i_tvalid=0 hold all counters.

## Test plan
- Write CTRL=1, BORDER=0x00FF00; send 2 frames of 480×1080 beats, gapless → o_enable=1, o_frame_done pulses twice, FRAME_CNT=2, o_border_rgb=0x00FF00 from frame 1 SOF+1, o_err=0.
- Write BORDER=0x0000FF mid-frame → o_border_rgb unchanged until the next SOF, then 0x0000FF.
- tlast at beat 300 on line 5 → ERR_LINE=1, o_err=1, line count advances to 6. Write STATUS=1 → ERR_LINE=0.
- tuser at line 200 beat 10 → ERR_FRAME=1; o_frame_done fires only after 1080 full lines counted from the new SOF.
- ONESHOT=1, EN=1 → exactly one o_frame_done, then state=IDLE, CTRL.EN reads 0, o_enable=0; a following SOF is ignored.
- Assert i_rst at line 500 → all outputs at reset values next cycle. FRAME_CNT reads 0 with rvalid 1 cycle after the read strobe.
